// File: rtl/addac_bist.sv
// Built-in self-test for the combinational addac block: sweeps every input
// vector, compacts the responses into a MISR and checks the result against GOLDEN.
module addac_bist #(
    parameter int unsigned        N_IN   = 5,
    parameter int unsigned        N_OUT  = 2,
    parameter int unsigned        SIG_W  = 16,
    parameter logic [SIG_W-1:0]   POLY   = 16'h1021,
    parameter logic [SIG_W-1:0]   SEED   = 16'h0000,
    parameter logic [SIG_W-1:0]   GOLDEN = 16'h0000,
    parameter int unsigned        SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     vec_count
);

    localparam int unsigned   CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [N_IN-1:0]     vec;
    logic [CNT_W-1:0]    settle_cnt;
    logic [SIG_W-1:0]    sig;
    logic [N_IN:0]       vcount;
    logic                pass_r;

    logic                settle_last;
    logic                vec_last;
    logic                launch;
    logic                kill;
    logic [SIG_W-1:0]    misr_next;

    assign settle_last = (settle_cnt == CNT_W'(SETTLE - 1));
    assign vec_last    = (vec == LAST_VEC);
    assign misr_next   = {sig[SIG_W-2:0], 1'b0}
                       ^ (sig[SIG_W-1] ? POLY : '0)
                       ^ SIG_W'(dut_out);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // abort outranks start everywhere, including a restart request from DONE
    always_comb begin
        state_n = state;
        launch  = 1'b0;
        kill    = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && start) begin
                    state_n = APPLY;
                    launch  = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_n = IDLE;
                    kill    = 1'b1;
                end else if (settle_last) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_n = IDLE;
                    kill    = 1'b1;
                end else if (vec_last) begin
                    state_n = COMPARE;
                end else begin
                    state_n = APPLY;
                end
            end
            COMPARE: begin
                if (abort) begin
                    state_n = IDLE;
                    kill    = 1'b1;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (abort) begin
                    state_n = IDLE;
                    kill    = 1'b1;
                end else if (start) begin
                    state_n = APPLY;
                    launch  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // signature and vec_count survive an abort so the partial run can be inspected
    always_ff @(posedge clk) begin
        if (!reset) begin
            vec        <= '0;
            settle_cnt <= '0;
            sig        <= '0;
            vcount     <= '0;
            pass_r     <= 1'b0;
        end else if (launch) begin
            vec        <= '0;
            settle_cnt <= '0;
            sig        <= SEED;
            vcount     <= '0;
            pass_r     <= 1'b0;
        end else if (kill) begin
            vec        <= '0;
            settle_cnt <= '0;
            pass_r     <= 1'b0;
        end else begin
            case (state)
                APPLY: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                CAPTURE: begin
                    sig        <= misr_next;
                    vcount     <= vcount + 1'b1;
                    settle_cnt <= '0;
                    if (!vec_last) begin
                        vec <= vec + 1'b1;
                    end
                end
                COMPARE: begin
                    pass_r <= (sig == GOLDEN);
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_in    = vec;
    assign busy      = (state == APPLY) || (state == CAPTURE) || (state == COMPARE);
    assign done      = (state == DONE);
    assign pass      = pass_r;
    assign signature = sig;
    assign vec_count = vcount;

endmodule

// File: tb/tb_addac_bist.sv
// Directed bench for addac_bist: one instance against simple stubs (GOLDEN=0),
// one against a reference combinational response with its signature as GOLDEN.
module tb_addac_bist;

    localparam logic [4:0] FAULT_VEC = 5'd24;

    function automatic logic [1:0] ref_resp(input logic [4:0] v, input logic flt);
        logic a, b, c, d, e;
        logic [1:0] r;
        {a, b, c, d, e} = v;
        r = {(a & b) | (c & (d ^ e)), a ^ b ^ c ^ d ^ e};
        if (flt && v == FAULT_VEC) r[1] = 1'b0;
        return r;
    endfunction

    function automatic logic [15:0] ref_sig(input int n, input logic flt);
        logic [15:0] s;
        s = 16'h0000;
        for (int v = 0; v < n; v++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
              ^ {14'b0, ref_resp(5'(v), flt)};
        end
        return s;
    endfunction

    localparam logic [15:0] REF_GOLDEN = ref_sig(32, 1'b0);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    int          mode = 0;
    logic        fault = 1'b0;

    logic [4:0]  dut_in_a, dut_in_b;
    logic [1:0]  dut_out_a, dut_out_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] sig_a, sig_b;
    logic [5:0]  cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_out_a = (mode == 1 && dut_in_a == 5'd31) ? 2'b01 :
                       (mode == 2 && dut_in_a == 5'd30) ? 2'b01 : 2'b00;
    assign dut_out_b = ref_resp(dut_in_b, fault);

    addac_bist #(.GOLDEN(16'h0000)) u_stub (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .signature(sig_a), .vec_count(cnt_a)
    );

    addac_bist #(.GOLDEN(REF_GOLDEN)) u_ref (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .signature(sig_b), .vec_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start a run, optionally re-pulse start at busy cycle pulse_at, count busy cycles
    task automatic run(input int pulse_at, output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        while (busy_a && cycles < 200) begin
            cycles++;
            start = (cycles == pulse_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        checks++;
        if ({dut_in_a, busy_a, done_a, pass_a, sig_a, cnt_a} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dut_in=%0d busy=%b done=%b pass=%b sig=%h cnt=%0d, want all zero",
                     dut_in_a, busy_a, done_a, pass_a, sig_a, cnt_a);
        end
    endtask

    task automatic test_zero_sweep();
        int cyc;
        mode = 0;
        run(0, cyc);
        checks++;
        if (cyc !== 65) begin errors++; $display("FAIL busy_cycles: got %0d want 65", cyc); end
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            errors++; $display("FAIL zero_done_pass: got done=%b pass=%b want 1 1", done_a, pass_a);
        end
        checks++;
        if (sig_a !== 16'h0000) begin errors++; $display("FAIL zero_sig: got %h want 0000", sig_a); end
        checks++;
        if (cnt_a !== 6'd32) begin errors++; $display("FAIL zero_count: got %0d want 32", cnt_a); end
        repeat (5) tick();
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 6'd32 || dut_in_a !== 5'd31) begin
            errors++;
            $display("FAIL done_hold: got done=%b busy=%b cnt=%0d dut_in=%0d want 1 0 32 31",
                     done_a, busy_a, cnt_a, dut_in_a);
        end
    endtask

    task automatic test_last_vector();
        int cyc;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 6'd0 || dut_in_a !== 5'd0) begin
            errors++;
            $display("FAIL restart_from_done: got done=%b busy=%b cnt=%0d dut_in=%0d want 0 1 0 0",
                     done_a, busy_a, cnt_a, dut_in_a);
        end
        cyc = 0;
        while (busy_a && cyc < 200) begin cyc++; tick(); end
        checks++;
        if (sig_a !== 16'h0001) begin errors++; $display("FAIL last_vec_sig: got %h want 0001", sig_a); end
        checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b0) begin
            errors++; $display("FAIL last_vec_pass: got done=%b pass=%b want 1 0", done_a, pass_a);
        end
    endtask

    task automatic test_shift_order();
        int cyc;
        mode = 2;
        run(0, cyc);
        checks++;
        if (sig_a !== 16'h0002) begin errors++; $display("FAIL shift_order_sig: got %h want 0002", sig_a); end
        checks++;
        if (cyc !== 65) begin errors++; $display("FAIL shift_order_cycles: got %0d want 65", cyc); end
    endtask

    task automatic test_reference();
        int cyc;
        mode = 0;
        fault = 1'b0;
        run(0, cyc);
        checks++;
        if (sig_b !== REF_GOLDEN || pass_b !== 1'b1 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL ref_good: got sig=%h pass=%b done=%b want sig=%h pass=1 done=1",
                     sig_b, pass_b, done_b, REF_GOLDEN);
        end
        fault = 1'b1;
        run(0, cyc);
        fault = 1'b0;
        checks++;
        if (sig_b !== ref_sig(32, 1'b1) || pass_b !== 1'b0) begin
            errors++;
            $display("FAIL ref_stuck_at: got sig=%h pass=%b want sig=%h pass=0",
                     sig_b, pass_b, ref_sig(32, 1'b1));
        end
    endtask

    task automatic test_abort();
        int cyc;
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (dut_in_a != 5'd10 && cyc < 200) begin cyc++; tick(); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || dut_in_a !== 5'd0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b pass=%b dut_in=%0d want 0 0 0 0",
                     busy_a, done_a, pass_a, dut_in_a);
        end
        checks++;
        if (cnt_b !== 6'd10 || sig_b !== ref_sig(10, 1'b0)) begin
            errors++;
            $display("FAIL abort_keeps_debug: got cnt=%0d sig=%h want cnt=10 sig=%h",
                     cnt_b, sig_b, ref_sig(10, 1'b0));
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || cnt_b !== 6'd10) begin
            errors++; $display("FAIL abort_beats_start_idle: got busy=%b cnt=%0d want 0 10", busy_a, cnt_b);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy_b !== 1'b1 || cnt_b !== 6'd0 || sig_b !== 16'h0000 || dut_in_b !== 5'd0) begin
            errors++;
            $display("FAIL rerun_after_abort: got busy=%b cnt=%0d sig=%h dut_in=%0d want 1 0 0000 0",
                     busy_b, cnt_b, sig_b, dut_in_b);
        end
        cyc = 0;
        while (busy_b && cyc < 200) begin cyc++; tick(); end
        checks++;
        if (cyc !== 65 || sig_b !== REF_GOLDEN || pass_b !== 1'b1) begin
            errors++;
            $display("FAIL rerun_complete: got cycles=%0d sig=%h pass=%b want 65 %h 1", cyc, sig_b, pass_b, REF_GOLDEN);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b0 || pass_b !== 1'b0 || dut_in_b !== 5'd0) begin
            errors++;
            $display("FAIL abort_beats_start_done: got done=%b busy=%b pass=%b dut_in=%0d want 0 0 0 0",
                     done_b, busy_b, pass_b, dut_in_b);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (dut_in_b != 5'd5 && cyc < 200) begin cyc++; tick(); end
        tick();
        checks++;
        if (cnt_b !== 6'd5 || busy_b !== 1'b1) begin
            errors++; $display("FAIL reach_capture: got cnt=%0d busy=%b want 5 1", cnt_b, busy_b);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({dut_in_b, busy_b, done_b, pass_b, sig_b, cnt_b} !== 30'd0) begin
            errors++;
            $display("FAIL reset_mid_capture: got dut_in=%0d busy=%b done=%b pass=%b sig=%h cnt=%0d want all zero",
                     dut_in_b, busy_b, done_b, pass_b, sig_b, cnt_b);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        mode = 0;
        run(20, cyc);
        checks++;
        if (cyc !== 65 || cnt_a !== 6'd32 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: got cycles=%0d cnt=%0d done=%b want 65 32 1", cyc, cnt_a, done_a);
        end
    endtask

    initial begin
        test_reset();
        test_zero_sweep();
        test_last_vector();
        test_shift_order();
        test_reference();
        test_abort();
        test_reset_mid_run();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addac_bist.md
Name: addac_bist

Overview:
- Hardware self-test engine for the combinational addac block (5 inputs a..e, 2 outputs saida1/saida2).
- Drives the DUT inputs instead of an external bench. It walks all 2^N_IN input combinations and compacts the DUT responses into a MISR signature.
- It compares the final signature against a golden value taken from the golden model, so the on-chip check matches what the vector bench checks.
- Sits beside addac. A top-level controller or scan-accessible register starts it and reads the result.

Parameters:
- N_IN, 5, DUT input width; vector space is 2^N_IN.
- N_OUT, 2, DUT output width; must satisfy N_OUT <= SIG_W.
- SIG_W, 16, MISR/signature width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 16'h0000, MISR initial value loaded at start.
- GOLDEN, 16'h0000, expected final signature, set at instantiation from the golden model.
- SETTLE, 1, cycles each vector is held before capture; legal range >= 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- abort  in  1  cancel a run in progress; returns to IDLE.
- dut_in  out  N_IN  vector applied to the DUT; bit N_IN-1 = a, bit 0 = e.
- dut_out  in  N_OUT  DUT response; bit N_OUT-1 = saida1, bit 0 = saida2.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE; sticky until next start or reset.
- pass  out  1  valid while done=1; 1 iff signature == GOLDEN.
- signature  out  SIG_W  current MISR value.
- vec_count  out  N_IN+1  number of vectors captured so far.

Behaviour:
- Reset (reset==0 at posedge), all outputs low/zero:
  - state=IDLE; dut_in=0, busy=0, done=0, pass=0, signature=0, vec_count=0.
  - Reset has priority over every other input and clears a run in progress mid-operation.
- States: IDLE, APPLY, CAPTURE, COMPARE, DONE.
- IDLE:
  - start=1 -> APPLY; vector register=0, settle counter=0, signature=SEED, vec_count=0, busy=1.
- APPLY:
  - dut_in = vector register, held stable.
  - Settle counter increments each cycle; after SETTLE cycles in APPLY -> CAPTURE.
- CAPTURE (one cycle), at its closing edge:
  - signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended dut_out.
  - vec_count increments.
  - If vector == 2^N_IN-1 -> COMPARE; else vector increments and state -> APPLY with settle counter cleared.
  - The vector register must not wrap to 0 and continue; the last vector always exits to COMPARE.
- COMPARE (one cycle): pass <= (signature == GOLDEN) -> DONE.
- DONE:
  - busy=0, done=1; pass and signature held; dut_in holds the last vector.
  - start=1 -> clears done/pass and enters APPLY exactly as from IDLE (restart).
- Busy duration: busy is high for 2^N_IN*(SETTLE+1)+1 cycles. With defaults that is 65; done rises on the cycle busy falls.
- start while busy: ignored.
- abort:
  - Effective in APPLY/CAPTURE/COMPARE: next state IDLE, busy=0, done=0, pass=0, dut_in=0.
  - signature and vec_count keep their values for debug.
  - abort and start asserted together in IDLE/DONE: abort wins and the state stays or becomes IDLE.
- dut_out is sampled only at the CAPTURE edge; changes at any other time have no effect.

Test Plan:
- DUT stub dut_out=2'b00 always, GOLDEN=0, SEED=0: pulse start -> busy high 65 cycles, vec_count=32, signature=16'h0000, done=1, pass=1.
- Stub outputs 2'b01 only when dut_in=5'd31, else 00 -> signature=16'h0001. With GOLDEN=0: pass=0, done=1.
- Stub outputs 2'b01 only when dut_in=5'd30 -> signature=16'h0002. Confirms shift order and ordering of the exhaustive sweep.
- Real addac instance with GOLDEN from the golden model -> pass=1. Force saida1 stuck-at-0 on one vector -> pass=0.
- Assert abort at vector 10 mid-APPLY -> next cycle IDLE, busy=0, done=0, dut_in=0. A following start re-runs from vector 0 with signature=SEED.
- Assert reset low mid-CAPTURE -> all outputs zero next cycle. Pulse start during busy -> no restart, and the count of busy cycles is unchanged.
